// File: rtl/imc_wb_if.sv
// Host buffer-space bus seen by the IMC compute sequencer.
interface imc_wb_if #(
  parameter int unsigned WIDTH_ADD = 8,
  parameter int unsigned DATA_W    = 32
);
  logic                 wb_valid;
  logic                 wb_rd_wr;
  logic [WIDTH_ADD-1:0] wb_buf_address;
  logic [DATA_W-1:0]    wb_wdata;
  logic [DATA_W-1:0]    status_rdata;

  // Host side drives the request and samples the status word.
  modport master (
    output wb_valid,
    output wb_rd_wr,
    output wb_buf_address,
    output wb_wdata,
    input  status_rdata
  );

  // Sequencer side decodes the request and returns the status word.
  modport slave (
    input  wb_valid,
    input  wb_rd_wr,
    input  wb_buf_address,
    input  wb_wdata,
    output status_rdata
  );
endinterface

// File: rtl/imc_compute_seq.sv
// In-memory-compute pass sequencer: steps rows through precharge, word-line,
// sense-amp settle and output-buffer latch, controlled through a WB register.
module imc_compute_seq #(
  parameter int unsigned          WIDTH_ADD = 8,
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          ROW_W     = 6,
  parameter int unsigned          SETTLE_W  = 4,
  parameter logic [WIDTH_ADD-1:0] CTRL_ADDR = WIDTH_ADD'(8'h42),
  parameter logic [WIDTH_ADD-1:0] STAT_ADDR = WIDTH_ADD'(8'h43)
) (
  input  logic             clk,
  input  logic             rst_n,
  imc_wb_if.slave          wb,
  output logic             busy,
  output logic             buf_wr_allow,
  output logic             done,
  output logic             irq,
  output logic             precharge_en,
  output logic             wl_en,
  output logic [ROW_W-1:0] wl_row,
  output logic             sa_en,
  output logic             ob_latch_en,
  output logic [ROW_W-1:0] ob_addr
);

  localparam int unsigned START_BIT    = 0;
  localparam int unsigned ABORT_BIT    = 1;
  localparam int unsigned LROW_LSB     = 8;
  localparam int unsigned SETTLE_LSB   = 16;
  localparam int unsigned STAT_ROW_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRECH = 3'd1,
    S_WL    = 3'd2,
    S_SENSE = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    r_last_row;
  logic [SETTLE_W-1:0] r_settle;
  logic [SETTLE_W-1:0] r_cnt;
  logic                r_done;
  logic                r_start_err;
  logic                r_aborted;
  logic                r_busy;
  logic                r_buf_wr_allow;
  logic                r_irq;
  logic                r_precharge_en;
  logic                r_wl_en;
  logic                r_sa_en;
  logic                r_ob_latch_en;
  logic [ROW_W-1:0]    r_wl_row;

  state_t              w_state_nxt;
  logic [ROW_W-1:0]    w_row_nxt;
  logic [ROW_W-1:0]    w_last_row_nxt;
  logic [SETTLE_W-1:0] w_settle_nxt;
  logic [SETTLE_W-1:0] w_cnt_nxt;
  logic                w_done_nxt;
  logic                w_start_err_nxt;
  logic                w_aborted_nxt;
  logic                w_busy_nxt;
  logic                w_irq_nxt;
  logic                w_precharge_nxt;
  logic                w_wl_nxt;
  logic                w_sa_nxt;
  logic                w_latch_nxt;
  logic [ROW_W-1:0]    w_wl_row_nxt;
  logic                w_set_done;
  logic                w_set_err;
  logic                w_set_abort;

  logic                w_ctrl_wr;
  logic                w_stat_rd;
  logic                w_start_req;
  logic                w_abort_req;
  logic                w_active;
  logic [ROW_W-1:0]    w_wr_last_row;
  logic [SETTLE_W-1:0] w_wr_settle;
  logic [SETTLE_W-1:0] w_settle_eff;
  logic [DATA_W-1:0]   w_status;
  logic                w_unused_wdata;

  // Register access decode; abort wins over start within one write.
  assign w_ctrl_wr     = wb.wb_valid & wb.wb_rd_wr & (wb.wb_buf_address == CTRL_ADDR);
  assign w_stat_rd     = wb.wb_valid & ~wb.wb_rd_wr & (wb.wb_buf_address == STAT_ADDR);
  assign w_abort_req   = w_ctrl_wr & wb.wb_wdata[ABORT_BIT];
  assign w_start_req   = w_ctrl_wr & wb.wb_wdata[START_BIT] & ~wb.wb_wdata[ABORT_BIT];
  assign w_wr_last_row = wb.wb_wdata[LROW_LSB +: ROW_W];
  assign w_wr_settle   = wb.wb_wdata[SETTLE_LSB +: SETTLE_W];
  assign w_settle_eff  = (w_wr_settle == '0) ? SETTLE_W'(1) : w_wr_settle;
  assign w_unused_wdata = ^wb.wb_wdata;

  assign w_active = (r_state == S_PRECH) || (r_state == S_WL) ||
                    (r_state == S_SENSE) || (r_state == S_LATCH);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_last_row_nxt = r_last_row;
    w_settle_nxt   = r_settle;
    w_cnt_nxt      = r_cnt;
    w_set_done     = 1'b0;
    w_set_err      = 1'b0;
    w_set_abort    = 1'b0;

    if (w_active && w_abort_req) begin
      w_state_nxt = S_IDLE;
      w_set_abort = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_req) begin
            w_state_nxt    = S_PRECH;
            w_row_nxt      = '0;
            w_last_row_nxt = w_wr_last_row;
            w_settle_nxt   = w_settle_eff;
          end else if ((r_state == S_DONE) && w_stat_rd) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRECH: w_state_nxt = S_WL;
        S_WL: begin
          w_state_nxt = S_SENSE;
          w_cnt_nxt   = r_settle;
        end
        S_SENSE: begin
          if (r_cnt <= SETTLE_W'(1)) begin
            w_state_nxt = S_LATCH;
          end else begin
            w_cnt_nxt = r_cnt - SETTLE_W'(1);
          end
        end
        S_LATCH: begin
          if (r_row == r_last_row) begin
            w_state_nxt = S_DONE;
            w_set_done  = 1'b1;
          end else begin
            w_state_nxt = S_PRECH;
            w_row_nxt   = r_row + ROW_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_active && w_start_req) begin
        w_set_err = 1'b1;
      end
    end

    // Sticky flags: a set event in the reading cycle wins over the read-clear.
    w_done_nxt      = w_set_done  | (r_done      & ~w_stat_rd);
    w_start_err_nxt = w_set_err   | (r_start_err & ~w_stat_rd);
    w_aborted_nxt   = w_set_abort | (r_aborted   & ~w_stat_rd);

    w_busy_nxt      = (w_state_nxt == S_PRECH) || (w_state_nxt == S_WL) ||
                      (w_state_nxt == S_SENSE) || (w_state_nxt == S_LATCH);
    w_precharge_nxt = (w_state_nxt == S_PRECH);
    w_wl_nxt        = (w_state_nxt == S_WL) || (w_state_nxt == S_SENSE);
    w_sa_nxt        = (w_state_nxt == S_SENSE);
    w_latch_nxt     = (w_state_nxt == S_LATCH);
    w_irq_nxt       = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    w_wl_row_nxt    = (w_wl_nxt || w_latch_nxt) ? w_row_nxt : r_wl_row;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_last_row     <= '0;
      r_settle       <= SETTLE_W'(1);
      r_cnt          <= '0;
      r_done         <= 1'b0;
      r_start_err    <= 1'b0;
      r_aborted      <= 1'b0;
      r_busy         <= 1'b0;
      r_buf_wr_allow <= 1'b1;
      r_irq          <= 1'b0;
      r_precharge_en <= 1'b0;
      r_wl_en        <= 1'b0;
      r_sa_en        <= 1'b0;
      r_ob_latch_en  <= 1'b0;
      r_wl_row       <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_row          <= w_row_nxt;
      r_last_row     <= w_last_row_nxt;
      r_settle       <= w_settle_nxt;
      r_cnt          <= w_cnt_nxt;
      r_done         <= w_done_nxt;
      r_start_err    <= w_start_err_nxt;
      r_aborted      <= w_aborted_nxt;
      r_busy         <= w_busy_nxt;
      r_buf_wr_allow <= ~w_busy_nxt;
      r_irq          <= w_irq_nxt;
      r_precharge_en <= w_precharge_nxt;
      r_wl_en        <= w_wl_nxt;
      r_sa_en        <= w_sa_nxt;
      r_ob_latch_en  <= w_latch_nxt;
      r_wl_row       <= w_wl_row_nxt;
    end
  end

  // Status word, driven only while the status register is being read.
  always_comb begin
    w_status                          = '0;
    w_status[0]                       = r_busy;
    w_status[1]                       = r_done;
    w_status[2]                       = r_aborted;
    w_status[3]                       = r_start_err;
    w_status[STAT_ROW_LSB +: ROW_W]   = r_row;
  end

  assign wb.status_rdata = w_stat_rd ? w_status : '0;

  assign busy         = r_busy;
  assign buf_wr_allow = r_buf_wr_allow;
  assign done         = r_done;
  assign irq          = r_irq;
  assign precharge_en = r_precharge_en;
  assign wl_en        = r_wl_en;
  assign sa_en        = r_sa_en;
  assign ob_latch_en  = r_ob_latch_en;
  assign wl_row       = r_wl_row;
  assign ob_addr      = r_wl_row;

endmodule

// File: tb/tb_imc_compute_seq.sv
// Directed and randomized bench for imc_compute_seq against a row/cycle list model.
module tb_imc_compute_seq;

  localparam int unsigned WIDTH_ADD = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROW_W     = 6;
  localparam int unsigned SETTLE_W  = 4;
  localparam logic [7:0]  CTRL      = 8'h42;
  localparam logic [7:0]  STAT      = 8'h43;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy, buf_wr_allow, done, irq;
  logic             precharge_en, wl_en, sa_en, ob_latch_en;
  logic [ROW_W-1:0] wl_row, ob_addr;

  imc_wb_if #(.WIDTH_ADD(WIDTH_ADD), .DATA_W(DATA_W)) wbif ();

  imc_compute_seq #(
    .WIDTH_ADD(WIDTH_ADD), .DATA_W(DATA_W), .ROW_W(ROW_W), .SETTLE_W(SETTLE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb(wbif),
    .busy(busy), .buf_wr_allow(buf_wr_allow), .done(done), .irq(irq),
    .precharge_en(precharge_en), .wl_en(wl_en), .wl_row(wl_row),
    .sa_en(sa_en), .ob_latch_en(ob_latch_en), .ob_addr(ob_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference flags as seen by the host.
  bit m_done, m_err, m_abort;
  int m_row;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy_b);
    return (32'(m_row) << 8) | {28'd0, m_err, m_abort, m_done, busy_b};
  endfunction

  // {precharge, wl, sa, ob_latch, busy, buf_wr_allow, irq, done}
  function automatic logic [31:0] obs_vec();
    return 32'({precharge_en, wl_en, sa_en, ob_latch_en, busy, buf_wr_allow, irq, done});
  endfunction

  function automatic logic [31:0] exp_vec(input logic [3:0] str, input bit b, input bit i);
    return 32'({str, b, ~b, i, m_done});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    wbif.wb_valid       = 1'b0;
    wbif.wb_rd_wr       = 1'b0;
    wbif.wb_buf_address = '0;
    wbif.wb_wdata       = '0;
  endtask

  task automatic ctrl_write(input logic [31:0] data);
    wbif.wb_valid       = 1'b1;
    wbif.wb_rd_wr       = 1'b1;
    wbif.wb_buf_address = CTRL;
    wbif.wb_wdata       = data;
    tick();
    idle_bus();
  endtask

  task automatic stat_read(input string tag);
    wbif.wb_valid       = 1'b1;
    wbif.wb_rd_wr       = 1'b0;
    wbif.wb_buf_address = STAT;
    #1;
    chk(tag, wbif.status_rdata, exp_status(1'b0));
    tick();
    idle_bus();
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_abort = 1'b0;
  endtask

  function automatic logic [31:0] start_word(input int last_row, input int settle);
    return (32'(settle) << 16) | (32'(last_row) << 8) | 32'd1;
  endfunction

  // One pass: expected per-cycle strobes are listed row by row; optional
  // write injected on cycle inj (abort truncates, start is just flagged).
  task automatic run_pass(input int last_row, input int settle, input int inj,
                          input logic [31:0] inj_data, input string tag);
    logic [3:0] q_str[$];
    int         q_row[$];
    int         s_eff;
    bit         aborted;
    s_eff   = (settle == 0) ? 1 : settle;
    aborted = 1'b0;
    for (int r = 0; r <= last_row; r++) begin
      q_str.push_back(4'b1000); q_row.push_back(r);
      q_str.push_back(4'b0100); q_row.push_back(r);
      for (int s = 0; s < s_eff; s++) begin
        q_str.push_back(4'b0110); q_row.push_back(r);
      end
      q_str.push_back(4'b0001); q_row.push_back(r);
    end
    ctrl_write(start_word(last_row, settle));
    m_row = 0;
    for (int i = 0; i < q_str.size(); i++) begin
      chk({tag, "_strobe"}, obs_vec(), exp_vec(q_str[i], 1'b1, 1'b0));
      if (q_str[i][2] || q_str[i][0])
        chk({tag, "_wl_row"}, 32'(wl_row), 32'(q_row[i]));
      if (q_str[i][0])
        chk({tag, "_ob_addr"}, 32'(ob_addr), 32'(q_row[i]));
      m_row = q_row[i];
      if (i == inj) begin
        ctrl_write(inj_data);
        if (inj_data[1]) begin
          m_abort = 1'b1;
          aborted = 1'b1;
          break;
        end else if (inj_data[0]) begin
          m_err = 1'b1;
        end
      end else begin
        tick();
      end
    end
    if (aborted) begin
      chk({tag, "_abort_idle"}, obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
      tick();
      chk({tag, "_abort_noirq"}, obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
    end else begin
      m_done = 1'b1;
      chk({tag, "_done_entry"}, obs_vec(), exp_vec(4'b0000, 1'b0, 1'b1));
      tick();
      chk({tag, "_done_hold"}, obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
    end
  endtask

  initial begin
    m_done = 1'b0; m_err = 1'b0; m_abort = 1'b0; m_row = 0;
    idle_bus();
    rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    chk("reset_outputs", obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
    chk("reset_wl_row", 32'(wl_row), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_outputs", obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
    stat_read("reset_status");

    // Single row, settle 2: 5 busy cycles then DONE, status read returns to IDLE
    run_pass(0, 2, -1, 32'd0, "p_r0_s2");
    stat_read("p_r0_s2_status");
    chk("p_r0_s2_cleared", obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));

    // Four rows settle 1 with a second start mid-pass
    run_pass(3, 1, 5, start_word(1, 1), "p_r3_s1");
    stat_read("start_err_status");
    chk("start_err_cleared", obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
    stat_read("start_err_reread");

    // Abort during SENSE of row 2 (5 cycles per row at settle 2)
    run_pass(4, 2, 12, 32'd2, "p_abort");
    stat_read("abort_status");

    // settle 0 behaves as 1, then restart straight from DONE
    run_pass(1, 0, -1, 32'd0, "p_s0");
    run_pass(2, 3, -1, 32'd0, "p_from_done");
    stat_read("from_done_status");

    // start|abort together from IDLE stays IDLE
    ctrl_write(32'h0000_0103);
    chk("start_abort_idle", obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
    tick();
    chk("start_abort_idle2", obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
    stat_read("start_abort_status");

    // Other addresses ignored: write start to STAT, read CTRL
    wbif.wb_valid = 1'b1; wbif.wb_rd_wr = 1'b1; wbif.wb_buf_address = STAT;
    wbif.wb_wdata = 32'd1;
    tick();
    wbif.wb_rd_wr = 1'b0; wbif.wb_buf_address = CTRL;
    #1;
    chk("ctrl_read_zero", wbif.status_rdata, 32'd0);
    tick();
    idle_bus();
    chk("stray_write_idle", obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));

    // Asynchronous reset while in WL, then a clean restart
    ctrl_write(start_word(2, 3));
    tick();
    chk("rst_pre_wl", obs_vec(), exp_vec(4'b0100, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    m_done = 1'b0; m_err = 1'b0; m_abort = 1'b0; m_row = 0;
    chk("rst_async_outputs", obs_vec(), exp_vec(4'b0000, 1'b0, 1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    run_pass(2, 1, -1, 32'd0, "p_after_rst");
    stat_read("after_rst_status");

    // Randomized passes, sometimes restarted from DONE without a read
    for (int k = 0; k < 8; k++) begin
      int lr, st;
      lr = int'($urandom_range(0, 7));
      st = int'($urandom_range(0, 5));
      run_pass(lr, st, -1, 32'd0, "p_rand");
      if ($urandom_range(0, 1) == 1) stat_read("rand_status");
    end
    stat_read("final_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
